// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin registered multiplexer.
//   DEF_WIDTH / DEF_N : default data width and channel count
//   ostate_t          : output-stage state (EMPTY = no word held, FULL = word held)
package rr_mux_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: rotating priority starting at ptr, or a forced
// channel when fixed_en=1.
//   req       : per-channel request
//   ptr       : highest-priority channel in rotating mode
//   fixed_en  : 1 = grant only fixed_sel (if requesting)
//   fixed_sel : forced channel
//   gnt       : one-hot grant (all zero when nothing granted)
//   gnt_idx   : index of granted channel (0 when nothing granted)
//   any_gnt   : a grant was issued
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            fixed_en,
    input  logic [SELW-1:0] fixed_sel,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any_gnt
);

    logic [SELW-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        if (fixed_en) begin
            if (req[fixed_sel]) begin
                gnt_idx = fixed_sel;
                any_gnt = 1'b1;
            end
        end else begin
            // Scan from the far end back toward ptr so the closest requester
            // (smallest offset) is written last and wins. N is a power of two,
            // so the SELW-bit add wraps modulo N for free.
            for (int k = N - 1; k >= 0; k--) begin
                cand = ptr + SELW'(k);
                if (req[cand]) begin
                    gnt_idx = cand;
                    any_gnt = 1'b1;
                end
            end
        end
        gnt = any_gnt ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel WIDTH-bit registered multiplexer with valid/ready on every input
// and on the output. Channel choice is round-robin or forced (fixed_en).
//   clock, reset_n       : clock, async active-low reset
//   in_data/in_valid     : channel i data at [i*WIDTH +: WIDTH], per-channel valid
//   in_ready             : per-channel accept, at most one bit high
//   fixed_en/fixed_sel   : forced-select mode and channel
//   out_data/out_sel     : registered word and the channel that supplied it
//   out_valid/out_ready  : output handshake
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               fixed_en,
    input  logic [SELW-1:0]    fixed_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    ostate_t                    state_q, state_d;
    logic    [SELW-1:0]         rr_ptr;
    logic    [N-1:0]            gnt;
    logic    [SELW-1:0]         gnt_idx;
    logic                       any_gnt;
    logic                       can_load;
    logic                       xfer;
    logic    [N-1:0][WIDTH-1:0] ch;

    assign ch = in_data;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .fixed_en  (fixed_en),
        .fixed_sel (fixed_sel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .any_gnt   (any_gnt)
    );

    assign out_valid = (state_q == FULL);
    // A full register may drain and reload in the same cycle.
    assign can_load  = !out_valid || out_ready;
    // reset_n gates the handshake so no channel sees a ready while in reset.
    assign in_ready  = gnt & {N{can_load & reset_n}};
    assign xfer      = any_gnt & can_load & reset_n;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (xfer) state_d = FULL;
                     else if (out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_sel  <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            out_data <= ch[gnt_idx];
            out_sel  <= gnt_idx;
            // Forced mode leaves the rotation untouched so round-robin resumes
            // where it left off.
            if (!fixed_en) rr_ptr <= gnt_idx + SELW'(1);
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;
    localparam int N = 8;
    localparam int W = 16;
    localparam int S = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid = '0;
    logic [N-1:0]     in_ready;
    logic             fixed_en = 1'b0;
    logic [S-1:0]     fixed_sel = '0;
    logic [W-1:0]     out_data;
    logic [S-1:0]     out_sel;
    logic             out_valid;
    logic             out_ready = 1'b1;

    logic [W-1:0]     chd [N];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit               m_valid = 0;
    logic [W-1:0]     m_data = '0;
    int               m_sel = 0;
    int               m_ptr = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
    end

    rr_mux_n #(.WIDTH(W), .N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fixed_en  (fixed_en),
        .fixed_sel (fixed_sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel wins under the stated rules; -1 when none.
    function automatic int exp_grant(input logic [N-1:0] v, input int ptr,
                                     input logic fen, input int fsel);
        if (fen) return v[fsel] ? fsel : -1;
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(negedge reset_n) begin
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else begin
            int g;
            bit can;
            can = !m_valid || out_ready;
            g = exp_grant(in_valid, m_ptr, fixed_en, int'(fixed_sel));
            if (can && g >= 0) begin
                m_valid = 1;
                m_data  = chd[g];
                m_sel   = g;
                if (!fixed_en) m_ptr = (g + 1) % N;
            end else if (out_ready && m_valid) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        int g;
        logic [N-1:0] er;
        g  = exp_grant(in_valid, m_ptr, fixed_en, int'(fixed_sel));
        er = (reset_n && (!m_valid || out_ready) && g >= 0) ? (N'(1) << g) : '0;
        chk("model.out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("model.out_data",  {16'b0, out_data}, {16'b0, m_data});
        chk("model.out_sel",   {29'b0, out_sel}, m_sel);
        chk("model.in_ready",  {24'b0, in_ready}, {24'b0, er});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) chd[i] = W'(16'h1000 + i);

        // reset / idle
        in_valid = 8'hFF;
        repeat (3) tick();
        #1;
        chk("rst.out_valid", {31'b0, out_valid}, 0);
        chk("rst.out_data",  {16'b0, out_data}, 0);
        chk("rst.in_ready",  {24'b0, in_ready}, 0);
        reset_n = 1'b1;
        #1;
        chk("rst.first_grant", {24'b0, in_ready}, 32'h01);

        // round-robin fairness
        for (int t = 0; t < 16; t++) begin
            tick();
            chk("rr.out_sel",  {29'b0, out_sel}, t % N);
            chk("rr.out_data", {16'b0, out_data}, 32'h1000 + (t % N));
        end

        // sparse requests and wrap-around: bring rr_ptr to 6 via ch5
        in_valid = 8'b0010_0000;
        tick();
        chk("sparse.ptr6", {29'b0, dut.rr_ptr}, 6);
        in_valid = 8'b0000_0101;
        tick();
        chk("sparse.sel0", {29'b0, out_sel}, 0);
        chk("sparse.ptr1", {29'b0, dut.rr_ptr}, 1);
        tick();
        chk("sparse.sel2", {29'b0, out_sel}, 2);
        tick();
        chk("sparse.sel0b", {29'b0, out_sel}, 0);

        // backpressure
        in_valid = '0;
        tick();
        chk("bp.drained", {31'b0, out_valid}, 0);
        chd[3] = 16'hBEEF;
        in_valid = 8'b0000_1000;
        tick();
        chk("bp.load_data", {16'b0, out_data}, 32'hBEEF);
        chk("bp.load_sel",  {29'b0, out_sel}, 3);
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp.in_ready", {24'b0, in_ready}, 0);
            chk("bp.hold_data", {16'b0, out_data}, 32'hBEEF);
            chk("bp.hold_sel", {29'b0, out_sel}, 3);
            chk("bp.hold_valid", {31'b0, out_valid}, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.reload_ready", {24'b0, in_ready}, 32'h10);
        tick();
        chk("bp.next_sel",  {29'b0, out_sel}, 4);
        chk("bp.next_data", {16'b0, out_data}, 32'h1004);
        tick();
        chk("bp.sel5", {29'b0, out_sel}, 5);

        // fixed mode; rr_ptr is 6 here and must stay there
        fixed_en  = 1'b1;
        fixed_sel = 3'd5;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("fix.sel", {29'b0, out_sel}, 5);
            chk("fix.ptr", {29'b0, dut.rr_ptr}, 6);
        end
        in_valid = 8'b1101_1111;
        #1;
        chk("fix.no_grant", {24'b0, in_ready}, 0);
        tick();
        chk("fix.drained", {31'b0, out_valid}, 0);
        chk("fix.sel_held", {29'b0, out_sel}, 5);

        // randomized phase
        for (int t = 0; t < 400; t++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & N'($urandom);
            in_valid  = v;
            out_ready = ($urandom_range(0, 3) != 0);
            fixed_en  = ($urandom_range(0, 7) == 0);
            fixed_sel = S'($urandom);
            for (int i = 0; i < N; i++) chd[i] = W'($urandom);
            tick();
        end

        // asynchronous reset mid-stream
        fixed_en  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int i = 0; i < N; i++) chd[i] = W'(16'h1000 + i);
        tick();
        chk("arst.pre_valid", {31'b0, out_valid}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.out_valid", {31'b0, out_valid}, 0);
        chk("arst.out_data",  {16'b0, out_data}, 0);
        chk("arst.in_ready",  {24'b0, in_ready}, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("arst.first_grant", {24'b0, in_ready}, 32'h01);
        tick();
        chk("arst.sel0",  {29'b0, out_sel}, 0);
        chk("arst.data0", {16'b0, out_data}, 32'h1000);
        tick();
        chk("arst.sel1",  {29'b0, out_sel}, 1);

        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
